// File: rtl/baud_acq_scheduler_pkg.sv
// Shared types and reset defaults for the baud/acquisition scheduler.
package baud_acq_scheduler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest usable round-down slot period in clocks
    localparam int DEF_MIN_PERIOD    = 2;

    localparam int DEFAULT_PERIOD    = 20;
    localparam int DEFAULT_UP_TIME   = 10;
    localparam int DEFAULT_DOWN_TIME = 5;

    typedef struct packed {
        logic [15:0] period;   // N: clocks per round-down slot
        logic [3:0]  up;       // U: slots of N+1 clocks
        logic [3:0]  down;     // D: slots of N clocks
    } cfg_t;

    localparam cfg_t DEFAULT_CFG = '{
        period: 16'(DEFAULT_PERIOD),
        up:     4'(DEFAULT_UP_TIME),
        down:   4'(DEFAULT_DOWN_TIME)
    };

    // Slots per bit; an empty bit still runs as a single slot
    function automatic logic [4:0] slotCount(input cfg_t c);
        logic [4:0] s;
        s = {1'b0, c.up} + {1'b0, c.down};
        return (s == 5'd0) ? 5'd1 : s;
    endfunction

endpackage

// File: rtl/baud_acq_scheduler_if.sv
// Config/control inputs and strobe outputs of the scheduler.
interface baud_acq_scheduler_if;

    logic [15:0] BaudRateGen_i;
    logic [3:0]  RoundUpNum_i;
    logic [3:0]  RoundDownNum_i;
    logic        p_CfgValid_i;
    logic        p_Enable_i;
    logic        p_Restart_i;
    logic        p_AcqSig_o;
    logic        p_MidSig_o;
    logic        p_BaudSig_o;
    logic [4:0]  AcqIdx_o;
    logic        p_Busy_o;

    modport master (
        output BaudRateGen_i, RoundUpNum_i, RoundDownNum_i,
        output p_CfgValid_i, p_Enable_i, p_Restart_i,
        input  p_AcqSig_o, p_MidSig_o, p_BaudSig_o, AcqIdx_o, p_Busy_o
    );

    modport slave (
        input  BaudRateGen_i, RoundUpNum_i, RoundDownNum_i,
        input  p_CfgValid_i, p_Enable_i, p_Restart_i,
        output p_AcqSig_o, p_MidSig_o, p_BaudSig_o, AcqIdx_o, p_Busy_o
    );

endinterface

// File: rtl/baud_acq_scheduler_acq_period_counter.sv
// Slot period counter: counts 0..lastVal, wraps, flags the terminal count.
module acq_period_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] lastVal,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    assign tc = (count == lastVal);

    // Synchronous clear has priority; wrap to zero on terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= tc ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/baud_acq_scheduler.sv
// Bit-timing scheduler: splits each bit into U slots of N+1 clocks followed
// by D slots of N clocks and emits acquisition / mid-bit / bit strobes.
module baud_acq_scheduler
    import baud_acq_scheduler_pkg::*;
#(
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    baud_acq_scheduler_if.slave  bus
);

    state_t           state, nextState;
    cfg_t             cfgIn, pendCfg, pendNext, actCfg;
    logic [4:0]       acqIdx, slotCnt, lastIdx, midIdx;
    logic [CNT_W-1:0] neff, lastVal;
    logic             running, restartNow, tc, acqRaw, baudRaw, loadAct;

    assign cfgIn    = '{period: bus.BaudRateGen_i, up: bus.RoundUpNum_i,
                        down: bus.RoundDownNum_i};
    // A capture in the same cycle as a load is seen by that load
    assign pendNext = bus.p_CfgValid_i ? cfgIn : pendCfg;

    assign running    = (state == RUN) & bus.p_Enable_i;
    assign restartNow = bus.p_Restart_i & bus.p_Enable_i;

    assign slotCnt = slotCount(actCfg);
    assign lastIdx = slotCnt - 5'd1;
    assign midIdx  = slotCnt >> 1;

    // Clamp the period and pick N+1 for the leading U slots
    always_comb begin
        neff = CNT_W'(actCfg.period);
        if (actCfg.period < 16'(MIN_PERIOD))
            neff = CNT_W'(MIN_PERIOD);
        lastVal = (acqIdx < {1'b0, actCfg.up}) ? neff : neff - 1'b1;
    end

    acq_period_counter #(.CNT_W(CNT_W)) uPeriod (
        .clk     (clk),
        .rst     (rst),
        .clr     (~running | restartNow),
        .en      (1'b1),
        .lastVal (lastVal),
        .tc      (tc)
    );

    // A restart aborts the slot, so its terminal count is not reported
    assign acqRaw  = running & tc & ~bus.p_Restart_i;
    assign baudRaw = acqRaw & (acqIdx == lastIdx);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state: start on enabled restart, fall back to IDLE on disable
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (restartNow)        nextState = RUN;
            RUN:     if (!bus.p_Enable_i)   nextState = IDLE;
            default:                        nextState = IDLE;
        endcase
    end

    // Outputs decoded from the counter state, gated by enable/restart
    always_comb begin
        bus.p_Busy_o    = (state == RUN);
        bus.p_AcqSig_o  = acqRaw;
        bus.p_MidSig_o  = acqRaw & (acqIdx == midIdx);
        bus.p_BaudSig_o = baudRaw;
        bus.AcqIdx_o    = acqIdx;
    end

    // Slot index: cleared outside RUN and on restart, wraps at bit end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acqIdx <= '0;
        else if (!running || restartNow)
            acqIdx <= '0;
        else if (acqRaw)
            acqIdx <= (acqIdx == lastIdx) ? 5'd0 : acqIdx + 5'd1;
    end

    // Active config only changes where a bit cannot be split by it
    assign loadAct = (state == IDLE) | restartNow | baudRaw;

    // Pending and active config shadows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendCfg <= DEFAULT_CFG;
            actCfg  <= DEFAULT_CFG;
        end else begin
            pendCfg <= pendNext;
            if (loadAct)
                actCfg <= pendNext;
        end
    end

endmodule

// File: tb/tb_baud_acq_scheduler.sv
// Directed bench: per-scenario stimulus records plus expected-output checkpoints.
module tb_baud_acq_scheduler;

    typedef struct {
        int   scen;
        int   cyc;
        logic acq, mid, baud, busy;
        int   idx;
    } chk_t;

    typedef struct {
        int cfgAt;
        int n, u, d;
        int restartAt2;
        int enOffAt;
        int rstFrom, rstTo;
        int len;
    } scen_t;

    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nVec = 0;
    int   nMis = 0;
    chk_t chk[$];
    scen_t scn[7];

    always #5 clk = ~clk;

    baud_acq_scheduler_if bus();

    baud_acq_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic addChk(input int s, input int c, input logic a, input logic m,
                          input logic b, input logic bz, input int i);
        chk_t e;
        e.scen = s; e.cyc = c; e.acq = a; e.mid = m; e.baud = b; e.busy = bz; e.idx = i;
        chk.push_back(e);
    endtask

    task automatic checkOut(input string name, input logic a, input logic m,
                            input logic b, input logic bz, input int i);
        logic [3:0] got, want;
        got  = {bus.p_AcqSig_o, bus.p_MidSig_o, bus.p_BaudSig_o, bus.p_Busy_o};
        want = {a, m, b, bz};
        nVec++;
        if (got !== want || bus.AcqIdx_o !== 5'(i)) begin
            nMis++;
            $display("FAIL %s: acq/mid/baud/busy=%b idx=%0d, expected %b idx=%0d",
                     name, got, bus.AcqIdx_o, want, i);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        nVec++;
        if (got != want) begin
            nMis++;
            $display("FAIL %s: counted %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic idleInputs();
        bus.BaudRateGen_i  = 16'd3;   // junk that must be ignored without CfgValid
        bus.RoundUpNum_i   = 4'd1;
        bus.RoundDownNum_i = 4'd1;
        bus.p_CfgValid_i   = 1'b0;
        bus.p_Enable_i     = 1'b0;
        bus.p_Restart_i    = 1'b0;
    endtask

    task automatic runScen(input int s);
        scen_t sc;
        int    nAcq, nMid;
        sc   = scn[s];
        nAcq = 0;
        nMid = 0;
        idleInputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < sc.len; c++) begin
            bus.p_Restart_i = (c == 0) || (c == sc.restartAt2);
            bus.p_Enable_i  = (c < sc.enOffAt);
            bus.p_CfgValid_i = (c == sc.cfgAt);
            if (c == sc.cfgAt) begin
                bus.BaudRateGen_i  = 16'(sc.n);
                bus.RoundUpNum_i   = 4'(sc.u);
                bus.RoundDownNum_i = 4'(sc.d);
            end else begin
                bus.BaudRateGen_i  = 16'd3;
                bus.RoundUpNum_i   = 4'd1;
                bus.RoundDownNum_i = 4'd1;
            end
            rst = (c >= sc.rstFrom) && (c < sc.rstTo);
            #1;
            foreach (chk[k])
                if (chk[k].scen == s && chk[k].cyc == c)
                    checkOut($sformatf("s%0d_cyc%0d", s, c), chk[k].acq, chk[k].mid,
                             chk[k].baud, chk[k].busy, chk[k].idx);
            if (c <= 310) begin
                nAcq += int'(bus.p_AcqSig_o);
                nMid += int'(bus.p_MidSig_o);
            end
            @(posedge clk); #1;
        end
        if (s == 0) begin
            checkCount("s0_acq_pulses_first_bit", nAcq, 15);
            checkCount("s0_mid_pulses_first_bit", nMid, 1);
        end
        idleInputs();
        rst = 1'b0;
    endtask

    initial begin
        //           cfgAt n  u  d  restart2 enOff  rstFrom rstTo len
        scn[0] = '{-1,   0, 0, 0, -1,      NEVER, -1,     -1,   621};  // defaults
        scn[1] = '{100,  8, 0, 4, -1,      NEVER, -1,     -1,   351};  // cfg mid-bit
        scn[2] = '{-1,   0, 0, 0, 150,     NEVER, -1,     -1,   461};  // restart mid-bit
        scn[3] = '{0,    1, 0, 0, -1,      NEVER, -1,     -1,   7};    // S=0, N<min
        scn[4] = '{-1,   0, 0, 0, 70,      63,    -1,     -1,   85};   // enable drop
        scn[5] = '{0,    8, 0, 4, 250,     NEVER, 200,    202,  272};  // async reset
        scn[6] = '{-1,   0, 0, 0, 21,      NEVER, -1,     -1,   43};   // restart on tc

        //     s  cyc  acq mid baud busy idx
        addChk(0, 0,   0, 0, 0, 0, 0);
        addChk(0, 1,   0, 0, 0, 1, 0);
        addChk(0, 20,  0, 0, 0, 1, 0);
        addChk(0, 21,  1, 0, 0, 1, 0);
        addChk(0, 22,  0, 0, 0, 1, 1);
        addChk(0, 168, 1, 1, 0, 1, 7);
        addChk(0, 210, 1, 0, 0, 1, 9);
        addChk(0, 211, 0, 0, 0, 1, 10);
        addChk(0, 230, 1, 0, 0, 1, 10);
        addChk(0, 309, 0, 0, 0, 1, 14);
        addChk(0, 310, 1, 0, 1, 1, 14);
        addChk(0, 311, 0, 0, 0, 1, 0);
        addChk(0, 478, 1, 1, 0, 1, 7);
        addChk(0, 620, 1, 0, 1, 1, 14);

        addChk(1, 168, 1, 1, 0, 1, 7);
        addChk(1, 310, 1, 0, 1, 1, 14);
        addChk(1, 317, 0, 0, 0, 1, 0);
        addChk(1, 318, 1, 0, 0, 1, 0);
        addChk(1, 326, 1, 0, 0, 1, 1);
        addChk(1, 334, 1, 1, 0, 1, 2);
        addChk(1, 342, 1, 0, 1, 1, 3);
        addChk(1, 350, 1, 0, 0, 1, 0);

        addChk(2, 147, 1, 0, 0, 1, 6);
        addChk(2, 150, 0, 0, 0, 1, 7);
        addChk(2, 151, 0, 0, 0, 1, 0);
        addChk(2, 168, 0, 0, 0, 1, 0);
        addChk(2, 171, 1, 0, 0, 1, 0);
        addChk(2, 318, 1, 1, 0, 1, 7);
        addChk(2, 460, 1, 0, 1, 1, 14);

        addChk(3, 1,   0, 0, 0, 1, 0);
        addChk(3, 2,   1, 1, 1, 1, 0);
        addChk(3, 3,   0, 0, 0, 1, 0);
        addChk(3, 4,   1, 1, 1, 1, 0);
        addChk(3, 6,   1, 1, 1, 1, 0);

        addChk(4, 42,  1, 0, 0, 1, 1);
        addChk(4, 62,  0, 0, 0, 1, 2);
        addChk(4, 63,  0, 0, 0, 1, 2);
        addChk(4, 64,  0, 0, 0, 0, 0);
        addChk(4, 71,  0, 0, 0, 0, 0);
        addChk(4, 84,  0, 0, 0, 0, 0);

        addChk(5, 8,   1, 0, 0, 1, 0);
        addChk(5, 32,  1, 0, 1, 1, 3);
        addChk(5, 200, 0, 0, 0, 0, 0);
        addChk(5, 203, 0, 0, 0, 0, 0);
        addChk(5, 251, 0, 0, 0, 1, 0);
        addChk(5, 258, 0, 0, 0, 1, 0);
        addChk(5, 271, 1, 0, 0, 1, 0);

        addChk(6, 21,  0, 0, 0, 1, 0);
        addChk(6, 22,  0, 0, 0, 1, 0);
        addChk(6, 42,  1, 0, 0, 1, 0);

        idleInputs();
        rst = 1'b1;
        #1;
        checkOut("reset_state", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int s = 0; s < 7; s++)
            runScen(s);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
